// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, the instruction memory request handshake and the IF/ID register.
// A one-entry hold buffer absorbs words that arrive during a stall; a pending register parks redirects that arrive mid-request.
module fetch_stage (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] IAddr,
   output logic        IReq,
   input  logic        IAck,
   input  logic [31:0] IRdata,
   input  logic        Stall,
   input  logic [1:0]  PCSrc,
   input  logic        BranchTaken,
   input  logic [31:0] BranchAddr,
   input  logic [31:0] JrAddr,
   input  logic        ErrInst,
   output logic [31:0] Instr_ID,
   output logic [31:0] PCPlus4_ID,
   output logic        Valid_ID,
   output logic [5:0]  Op,
   output logic [5:0]  Funct
);

   localparam logic [31:0] reset_pc   = 32'h8000_0000;
   localparam logic [31:0] err_vector = 32'h8000_0008;
   localparam logic [1:0]  pcsrc_br   = 2'b01;
   localparam logic [1:0]  pcsrc_j    = 2'b10;
   localparam logic [1:0]  pcsrc_jr   = 2'b11;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_plus4;
   logic [31:0] buf_instr, buf_pc4;
   logic [31:0] pending;
   logic [31:0] target;
   logic        redirect;

   assign pc_plus4 = pc + 32'd4;
   assign IAddr    = pc;
   assign Op       = Instr_ID[31:26];
   assign Funct    = Instr_ID[5:0];

   // Redirect decision and target; ErrInst outranks any control transfer.
   always_comb begin
      redirect = Valid_ID & ~Stall &
                 (ErrInst | (PCSrc == pcsrc_j) | (PCSrc == pcsrc_jr) |
                  ((PCSrc == pcsrc_br) & BranchTaken));
      if (ErrInst)
         target = err_vector;
      else if (PCSrc == pcsrc_jr)
         // A user-mode PC cannot reach supervisor space through a register jump.
         target = {PCPlus4_ID[31] & JrAddr[31], JrAddr[30:0]};
      else if (PCSrc == pcsrc_j)
         target = {PCPlus4_ID[31:28], Instr_ID[25:0], 2'b00};
      else
         target = BranchAddr;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = FETCH;
         FETCH: begin
            if (IAck && !redirect && Stall) state_nxt = HOLD;
            else if (!IAck && redirect)     state_nxt = DROP;
         end
         HOLD:  if (redirect || !Stall) state_nxt = FETCH;
         DROP:  if (IAck) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
   always_comb begin
      IReq = 1'b0;
      case (state)
         FETCH, DROP: IReq = 1'b1;
         default:     IReq = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc         <= reset_pc;
         Instr_ID   <= '0;
         PCPlus4_ID <= '0;
         Valid_ID   <= 1'b0;
         buf_instr  <= '0;
         buf_pc4    <= '0;
         pending    <= '0;
      end else begin
         // No delay slot: the instruction behind a taken redirect never reaches ID.
         if (redirect) begin
            Instr_ID <= '0;
            Valid_ID <= 1'b0;
         end
         case (state)
            FETCH: begin
               if (IAck) begin
                  if (redirect) begin
                     pc <= target;
                  end else begin
                     pc <= pc_plus4;
                     if (Stall) begin
                        buf_instr <= IRdata;
                        buf_pc4   <= pc_plus4;
                     end else begin
                        Instr_ID   <= IRdata;
                        PCPlus4_ID <= pc_plus4;
                        Valid_ID   <= 1'b1;
                     end
                  end
               end else if (redirect) begin
                  pending <= target;
               end else if (!Stall) begin
                  Valid_ID <= 1'b0;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc <= target;
               end else if (!Stall) begin
                  Instr_ID   <= buf_instr;
                  PCPlus4_ID <= buf_pc4;
                  Valid_ID   <= 1'b1;
               end
            end
            DROP: if (IAck) pc <= pending;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios from reset, then randomized traffic
// compared cycle by cycle against a queue-based reference model of the fetch rules.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IAddr;
   logic        IReq;
   logic        IAck;
   logic [31:0] IRdata;
   logic        Stall;
   logic [1:0]  PCSrc;
   logic        BranchTaken;
   logic [31:0] BranchAddr;
   logic [31:0] JrAddr;
   logic        ErrInst;
   logic [31:0] Instr_ID;
   logic [31:0] PCPlus4_ID;
   logic        Valid_ID;
   logic [5:0]  Op;
   logic [5:0]  Funct;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_stage dut (
      .clk(clk), .reset(reset), .IAddr(IAddr), .IReq(IReq), .IAck(IAck), .IRdata(IRdata),
      .Stall(Stall), .PCSrc(PCSrc), .BranchTaken(BranchTaken), .BranchAddr(BranchAddr),
      .JrAddr(JrAddr), .ErrInst(ErrInst), .Instr_ID(Instr_ID), .PCPlus4_ID(PCPlus4_ID),
      .Valid_ID(Valid_ID), .Op(Op), .Funct(Funct)
   );

   always #5 clk = ~clk;

   // Reference model: a fetch engine that is either not started, waiting on a
   // parked word (hold queue), draining a request whose target is queued, or fetching.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } entry_t;

   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   bit          m_started;
   entry_t      m_hold[$];
   logic [31:0] m_pend[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h8000_0000;
      m_instr   = '0;
      m_pc4     = '0;
      m_valid   = 1'b0;
      m_started = 1'b0;
      m_hold.delete();
      m_pend.delete();
   endtask

   task automatic model_step();
      bit          redir;
      logic [31:0] tgt;
      entry_t      e;
      redir = m_valid && !Stall &&
              (ErrInst || PCSrc == 2'd2 || PCSrc == 2'd3 || (PCSrc == 2'd1 && BranchTaken));
      if (ErrInst)            tgt = 32'h8000_0008;
      else if (PCSrc == 2'd3) tgt = {m_pc4[31] & JrAddr[31], JrAddr[30:0]};
      else if (PCSrc == 2'd2) tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
      else                    tgt = BranchAddr;

      if (!m_started) begin
         m_started = 1'b1;
      end else if (m_pend.size() != 0) begin
         if (IAck) m_pc = m_pend.pop_front();
      end else if (m_hold.size() != 0) begin
         if (redir) begin
            m_hold.delete();
            m_pc = tgt;
         end else if (!Stall) begin
            e       = m_hold.pop_front();
            m_instr = e.instr;
            m_pc4   = e.pc4;
            m_valid = 1'b1;
         end
      end else if (IAck) begin
         if (redir) begin
            m_pc = tgt;
         end else begin
            if (Stall) begin
               e.instr = IRdata;
               e.pc4   = m_pc + 32'd4;
               m_hold.push_back(e);
            end else begin
               m_instr = IRdata;
               m_pc4   = m_pc + 32'd4;
               m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
         end
      end else if (redir) begin
         m_pend.push_back(tgt);
      end else if (!Stall) begin
         m_valid = 1'b0;
      end

      if (redir) begin
         m_instr = '0;
         m_valid = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      logic exp_req;
      exp_req = m_started && (m_hold.size() == 0);
      check({tag, ".IAddr"},      IAddr,            m_pc);
      check({tag, ".IReq"},       32'(IReq),        32'(exp_req));
      check({tag, ".Instr_ID"},   Instr_ID,         m_instr);
      check({tag, ".PCPlus4_ID"}, PCPlus4_ID,       m_pc4);
      check({tag, ".Valid_ID"},   32'(Valid_ID),    32'(m_valid));
      check({tag, ".Op"},         32'(Op),          32'(m_instr[31:26]));
      check({tag, ".Funct"},      32'(Funct),       32'(m_instr[5:0]));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      IAck = 1'b0; IRdata = '0; Stall = 1'b0; PCSrc = 2'd0; BranchTaken = 1'b0;
      BranchAddr = '0; JrAddr = '0; ErrInst = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      model_reset();
      #12;
      check("rst.IAddr",    IAddr,          32'h8000_0000);
      check("rst.IReq",     32'(IReq),      32'd0);
      check("rst.Instr_ID", Instr_ID,       32'd0);
      check("rst.PCPlus4",  PCPlus4_ID,     32'd0);
      check("rst.Valid_ID", 32'(Valid_ID),  32'd0);
      check("rst.OpFunct",  32'({Op, Funct}), 32'd0);

      // Reset release with IAck tied high.
      @(negedge clk);
      reset = 1'b1; IAck = 1'b1; IRdata = 32'h0000_0020;
      cycle("boot1");
      check("boot1.ireq_const",  32'(IReq), 32'd1);
      check("boot1.iaddr_const", IAddr,     32'h8000_0000);
      cycle("boot2");
      check("boot2.instr_const", Instr_ID,   32'h0000_0020);
      check("boot2.pc4_const",   PCPlus4_ID, 32'h8000_0004);
      check("boot2.valid_const", 32'(Valid_ID), 32'd1);
      check("boot2.iaddr_const", IAddr,      32'h8000_0004);

      // Stall during an acknowledged fetch parks the word.
      Stall = 1'b1; IRdata = 32'h8C01_0004;
      cycle("stall1");
      check("stall1.ireq_const",  32'(IReq), 32'd0);
      check("stall1.instr_const", Instr_ID,  32'h0000_0020);
      Stall = 1'b0; IAck = 1'b0;
      cycle("stall2");
      check("stall2.instr_const", Instr_ID, 32'h8C01_0004);

      // Taken branch with a simultaneous acknowledge drops the fetched word.
      PCSrc = 2'd1; BranchTaken = 1'b1; BranchAddr = 32'h8000_0100; IAck = 1'b1; IRdata = 32'hDEAD_BEEF;
      cycle("br1");
      check("br1.valid_const", 32'(Valid_ID), 32'd0);
      check("br1.iaddr_const", IAddr,         32'h8000_0100);
      PCSrc = 2'd0; BranchTaken = 1'b0; IRdata = 32'h0;
      cycle("br2");
      // Branch into user space so the next instruction has PC+4 = 0x10.
      PCSrc = 2'd1; BranchTaken = 1'b1; BranchAddr = 32'h0000_000C;
      cycle("br3");
      PCSrc = 2'd0; BranchTaken = 1'b0; IRdata = 32'h0000_0008;
      cycle("br4");
      check("br4.pc4_const", PCPlus4_ID, 32'h0000_0010);

      // JR from user mode while the request is outstanding.
      PCSrc = 2'd3; JrAddr = 32'h8000_1000; IAck = 1'b0;
      cycle("jr1");
      check("jr1.iaddr_held", IAddr,     32'h0000_0010);
      check("jr1.ireq_const", 32'(IReq), 32'd1);
      PCSrc = 2'd0;
      cycle("jr2");
      IAck = 1'b1;
      cycle("jr3");
      check("jr3.iaddr_const", IAddr, 32'h0000_1000);

      // Illegal instruction outranks a J.
      IRdata = 32'h0800_0000;
      cycle("err1");
      ErrInst = 1'b1; PCSrc = 2'd2;
      cycle("err2");
      check("err2.iaddr_const", IAddr,         32'h8000_0008);
      check("err2.valid_const", 32'(Valid_ID), 32'd0);
      ErrInst = 1'b0; PCSrc = 2'd0; IRdata = 32'h0;
      cycle("err3");

      // Reset asserted while draining a request.
      PCSrc = 2'd2; IAck = 1'b0;
      cycle("drop1");
      reset = 1'b0;
      #1;
      model_reset();
      check("drop_rst.IReq",  32'(IReq),     32'd0);
      check("drop_rst.IAddr", IAddr,         32'h8000_0000);
      check("drop_rst.Valid", 32'(Valid_ID), 32'd0);
      check_all("drop_rst");
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      cycle("rst_idle");
      check("rst_idle.ireq_const", 32'(IReq), 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         IAck        = ($urandom_range(0, 9) < 6);
         IRdata      = $urandom;
         Stall       = ($urandom_range(0, 3) == 0);
         PCSrc       = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
         BranchTaken = $urandom_range(0, 1) == 1;
         BranchAddr  = {$urandom_range(0, 1) == 1, 31'($urandom)};
         JrAddr      = $urandom;
         ErrInst     = ($urandom_range(0, 19) == 0);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port IAddr, output, 32 bits: instruction memory word address, equal to the current PC.
REQ-004 The block SHALL have the port IReq, output, 1 bit: instruction memory read request.
REQ-005 The block SHALL have the port IAck, input, 1 bit: memory has completed the current request; IRdata is valid in the same cycle.
REQ-006 The block SHALL have the port IRdata, input, 32 bits: instruction word returned by memory.
REQ-007 The block SHALL have the port Stall, input, 1 bit: hazard hold; the IF/ID register keeps its contents.
REQ-008 The block SHALL have the port PCSrc, input, 2 bits, from the decoder: 00 sequential, 01 branch, 10 J/JAL, 11 JR/JALR.
REQ-009 The block SHALL have the port BranchTaken, input, 1 bit: branch condition true.
REQ-010 The block SHALL have the port BranchAddr, input, 32 bits: computed branch target.
REQ-011 The block SHALL have the port JrAddr, input, 32 bits: register target for JR/JALR.
REQ-012 The block SHALL have the port ErrInst, input, 1 bit: the decoder flags the ID instruction as illegal.
REQ-013 The block SHALL have the port Instr_ID, output, 32 bits: the IF/ID instruction register.
REQ-014 The block SHALL have the port PCPlus4_ID, output, 32 bits: PC+4 of the instruction in Instr_ID.
REQ-015 The block SHALL have the port Valid_ID, output, 1 bit: Instr_ID holds a real instruction.
REQ-016 The block SHALL have the ports Op and Funct, outputs, 6 bits each, driven combinationally as Op = Instr_ID[31:26] and Funct = Instr_ID[5:0].

Function
REQ-017 FSM states SHALL be IDLE, FETCH, HOLD and DROP.
REQ-018 IReq SHALL be 1 in FETCH and DROP and 0 in IDLE and HOLD.
REQ-019 Once IReq is raised, IAddr SHALL be held stable until the cycle in which IAck=1.
REQ-020 IDLE SHALL last one cycle after reset is released and then move to FETCH.
REQ-021 Redirect SHALL be asserted when Valid_ID & !Stall & (ErrInst | PCSrc==10 | PCSrc==11 | (PCSrc==01 & BranchTaken)).
REQ-022 Redirect target priority SHALL be:
 - ErrInst first, giving target 0x80000008;
 - then JR, giving {PCPlus4_ID[31] & JrAddr[31], JrAddr[30:0]};
 - then J, giving {PCPlus4_ID[31:28], Instr_ID[25:0], 2'b00};
 - then branch, giving BranchAddr.
REQ-023 The JR target rule SHALL ensure that a user-mode PC (bit 31 = 0) never enters supervisor space.
REQ-024 On redirect, Valid_ID SHALL be cleared and Instr_ID set to 0 at the next edge; there is no delay slot.
REQ-025 In FETCH, when IAck=1 and there is no redirect and Stall=0:
 - Instr_ID <= IRdata, PCPlus4_ID <= PC+4 and Valid_ID <= 1;
 - PC <= PC+4;
 - the FSM stays in FETCH.
REQ-026 In FETCH, when IAck=1, there is no redirect and Stall=1: IRdata and PC+4 SHALL be captured in a one-entry buffer, PC <= PC+4, and the FSM moves to HOLD.
REQ-027 In HOLD, when Stall=0: the buffer SHALL be loaded into IF/ID with Valid_ID <= 1, and the FSM moves to FETCH.
REQ-028 In HOLD, when a redirect occurs: the buffer SHALL be discarded, PC <= target, and the FSM moves to FETCH.
REQ-029 In FETCH, when IAck=1 and a redirect occurs in the same cycle: IRdata SHALL be discarded, PC <= target, and the FSM stays in FETCH.
REQ-030 In FETCH, when IAck=0 and a redirect occurs: the target SHALL be saved in a pending register, and the FSM moves to DROP.
REQ-031 In DROP, when IAck=1: the data SHALL be discarded, PC <= pending target, and the FSM moves to FETCH.
REQ-032 In FETCH, when IAck=0, Stall=0 and there is no redirect: Valid_ID SHALL be set to 0 (bubble).
REQ-033 Whenever Stall=1 and there is no redirect, the IF/ID register SHALL be unchanged.
REQ-034 PC+4 SHALL be a 32-bit add that wraps modulo 2^32, with bit 31 included in the add.

Reset
REQ-035 While reset=0, the following SHALL apply immediately (asynchronous reset):
 - PC = 0x80000000 and IAddr = 0x80000000;
 - IReq = 0;
 - Instr_ID = 0, PCPlus4_ID = 0 and Valid_ID = 0 (so Op = 0 and Funct = 0);
 - the buffer and pending registers = 0;
 - the FSM is in IDLE.
REQ-036 Reset asserted mid-request SHALL abandon the request with no handshake completion required.

Verification
REQ-037 Reset release with IAck tied to 1 and IRdata = 0x00000020 -> the checks SHALL be:
 - cycle 1: IReq=1 with IAddr=0x80000000;
 - next edge: Instr_ID=0x00000020, PCPlus4_ID=0x80000004, Valid_ID=1;
 - IAddr=0x80000004.
REQ-038 Stall=1 during an IAck with IRdata=0x8C010004 -> the checks SHALL be:
 - the FSM enters HOLD with IReq=0 and Instr_ID unchanged;
 - after Stall is deasserted, Instr_ID=0x8C010004 at the next edge.
REQ-039 Valid_ID=1, PCSrc=01, BranchTaken=1, BranchAddr=0x80000100 and IAck=1 in the same cycle -> the checks SHALL be:
 - Valid_ID=0 at the next edge;
 - the next IAddr is 0x80000100;
 - the fetched word is dropped.
REQ-040 Valid_ID=1, PCSrc=11, JrAddr=0x80001000, PCPlus4_ID=0x00000010 and IAck=0 -> the checks SHALL be:
 - the FSM enters DROP with IAddr held;
 - after IAck, IAddr=0x00001000.
REQ-041 Valid_ID=1, ErrInst=1 and PCSrc=10 -> the next IAddr SHALL be 0x80000008 and Valid_ID=0.
REQ-042 Reset asserted while in DROP -> IReq=0, PC=0x80000000 and the FSM in IDLE SHALL hold immediately.
